mm_host_arbiter: RTL and testbench

MM_HOST_ARBITER -- requirements
Module: mm_host_arbiter

---
 rtl/mm_host_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mm_host_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_host_arbiter.sv
// mm_host_arbiter: round-robin arbiter that grants one of NREQ burst
// requesters (0 = loader A, 1 = loader B, 2 = writer) the single host
// command/beat bus, one burst at a time.
// Optional feature: define MM_ARB_WATCHDOG_EN to add a stall watchdog that
// aborts a burst after TIMEOUT stalled cycles and raises a sticky err.
module mm_host_arbiter #(
  parameter int NREQ    = 3,
  parameter int LENW    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][31:0]      req_addr,
  input  logic [NREQ-1:0][LENW-1:0]  req_len,
  input  logic [NREQ-1:0]            req_we,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            req_done,
  output logic [NREQ-1:0]            owner,
  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic [31:0]                m_cmd_addr,
  output logic [LENW-1:0]            m_cmd_len,
  output logic                       m_cmd_we,
  input  logic                       m_beat,
  output logic                       busy,
  output logic                       err
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CMD, XFER} state_e;

  state_e          state_q;
  logic [PTRW-1:0] ptr_q;
  logic [PTRW-1:0] owner_idx_q;
  logic [NREQ-1:0] owner_q;
  logic [NREQ-1:0] req_done_q;
  logic            m_cmd_valid_q;
  logic [31:0]     m_cmd_addr_q;
  logic [LENW-1:0] m_cmd_len_q;
  logic            m_cmd_we_q;
  logic [LENW-1:0] beat_cnt_q;

  logic            grant_found;
  logic [PTRW-1:0] grant_idx;
  logic [PTRW-1:0] cand_idx;
  logic [NREQ-1:0] grant_oh;
  logic            wd_fire;

  // Round-robin search starting at the requester after the last owner.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it holding a value (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    grant_oh    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = PTRW'((int'(ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (grant_found) grant_oh[grant_idx] = 1'b1;
  end

  // Burst control FSM; all outputs except the accept pulse are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= PTRW'(NREQ - 1);
      owner_idx_q   <= '0;
      owner_q       <= '0;
      req_done_q    <= '0;
      m_cmd_valid_q <= 1'b0;
      m_cmd_addr_q  <= '0;
      m_cmd_len_q   <= '0;
      m_cmd_we_q    <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      req_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            m_cmd_addr_q <= req_addr[grant_idx];
            m_cmd_len_q  <= req_len[grant_idx];
            m_cmd_we_q   <= req_we[grant_idx];
            if (req_len[grant_idx] != '0) begin
              owner_q       <= grant_oh;
              owner_idx_q   <= grant_idx;
              m_cmd_valid_q <= 1'b1;
              state_q       <= CMD;
            end else begin
              // Empty burst: complete immediately without touching the host bus.
              req_done_q <= grant_oh;
              ptr_q      <= grant_idx;
            end
          end
        end
        CMD: begin
          if (wd_fire) begin
            m_cmd_valid_q <= 1'b0;
            req_done_q    <= owner_q;
            ptr_q         <= owner_idx_q;
            owner_q       <= '0;
            state_q       <= IDLE;
          end else if (m_cmd_ready) begin
            m_cmd_valid_q <= 1'b0;
            beat_cnt_q    <= m_cmd_len_q;
            state_q       <= XFER;
          end
        end
        XFER: begin
          if (wd_fire) begin
            req_done_q <= owner_q;
            ptr_q      <= owner_idx_q;
            owner_q    <= '0;
            state_q    <= IDLE;
          end else if (m_beat) begin
            beat_cnt_q <= beat_cnt_q - LENW'(1);
            if (beat_cnt_q == LENW'(1)) begin
              req_done_q <= owner_q;
              ptr_q      <= owner_idx_q;
              owner_q    <= '0;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MM_ARB_WATCHDOG_EN
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WDW-1:0] wd_cnt_q;
  logic           err_q;
  logic           wd_stall;

  assign wd_stall = ((state_q == CMD) && !m_cmd_ready) || ((state_q == XFER) && !m_beat);
  assign wd_fire  = wd_stall && (wd_cnt_q == WDW'(TIMEOUT - 1));

  // Count consecutive stalled cycles; any progress or idle clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (wd_fire) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b1;
    end else if (wd_stall) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end else begin
      wd_cnt_q <= '0;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign wd_fire        = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // A grant is never offered while reset is swallowing the arbitration.
  assign req_ready   = ((state_q == IDLE) && !rst) ? grant_oh : '0;
  assign req_done    = req_done_q;
  assign owner       = owner_q;
  assign m_cmd_valid = m_cmd_valid_q;
  assign m_cmd_addr  = m_cmd_addr_q;
  assign m_cmd_len   = m_cmd_len_q;
  assign m_cmd_we    = m_cmd_we_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mm_host_arbiter.sv
// tb_mm_host_arbiter: directed self-checking bench for mm_host_arbiter.
// Inputs are driven 2 time units after the rising edge, outputs sampled
// 1 unit later, well away from the active edge.
module tb_mm_host_arbiter;
  localparam int NREQ    = 3;
  localparam int LENW    = 16;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][31:0]     req_addr;
  logic [NREQ-1:0][LENW-1:0] req_len;
  logic [NREQ-1:0]           req_we;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           req_done;
  logic [NREQ-1:0]           owner;
  logic                      m_cmd_valid;
  logic                      m_cmd_ready;
  logic [31:0]               m_cmd_addr;
  logic [LENW-1:0]           m_cmd_len;
  logic                      m_cmd_we;
  logic                      m_beat;
  logic                      busy;
  logic                      err;

  int tests = 0;
  int fails = 0;

  mm_host_arbiter #(.NREQ(NREQ), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_we(req_we),
    .req_ready(req_ready), .req_done(req_done), .owner(owner),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
    .m_cmd_len(m_cmd_len), .m_cmd_we(m_cmd_we), .m_beat(m_beat),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    m_cmd_ready = 1'b0;
    m_beat      = 1'b0;
  endtask

  // Leaves the DUT in its first post-reset IDLE cycle with rst low.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_cmd_ready = 1'b1;
    m_beat = 1'b1;
    tick();
    tick();
    #1;
    if ({req_done, owner, m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_we, busy, err} !== '0) begin
      $display("FAIL reset_regs: got %h want 0",
               {req_done, owner, m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_we, busy, err});
      fails++;
    end
    tests++;
    rst = 1'b0;
    idle_inputs();
    #1;
    if ({req_ready, busy, err} !== '0) begin
      $display("FAIL reset_idle: got %b want 0", {req_ready, busy, err});
      fails++;
    end
    tests++;
  endtask

  task automatic test_single();
    req_valid = 3'b010; req_addr[1] = 32'h0000_1000; req_len[1] = 16'd1; req_we[1] = 1'b0;
    m_cmd_ready = 1'b1; m_beat = 1'b0;
    #1;
    if (req_ready !== 3'b010 || m_cmd_valid !== 1'b0) begin
      $display("FAIL single_grant: got ready=%b mcv=%b want 010/0", req_ready, m_cmd_valid);
      fails++;
    end
    tests++;
    tick();
    req_valid = '0;
    #1;
    if (m_cmd_valid !== 1'b1 || m_cmd_addr !== 32'h1000 || m_cmd_len !== 16'd1 ||
        m_cmd_we !== 1'b0 || owner !== 3'b010) begin
      $display("FAIL single_cmd: got v=%b a=%h l=%0d we=%b own=%b want 1/1000/1/0/010",
               m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_we, owner);
      fails++;
    end
    tests++;
    tick();
    m_beat = 1'b1;
    #1;
    if (req_done !== 3'b000 || busy !== 1'b1) begin
      $display("FAIL single_xfer: got done=%b busy=%b want 000/1", req_done, busy);
      fails++;
    end
    tests++;
    tick();
    m_beat = 1'b0;
    #1;
    if (req_done !== 3'b010 || owner !== 3'b000 || busy !== 1'b0) begin
      $display("FAIL single_done: got done=%b own=%b busy=%b want 010/000/0", req_done, owner, busy);
      fails++;
    end
    tests++;
    tick();
    #1;
    if (req_done !== 3'b000) begin
      $display("FAIL single_done_pulse: got %b want 000", req_done);
      fails++;
    end
    tests++;
  endtask

  task automatic test_len_zero();
    logic mcv_seen;
    req_valid = 3'b100; req_addr[2] = 32'h0000_2000; req_len[2] = 16'd0; req_we[2] = 1'b1;
    m_cmd_ready = 1'b1;
    #1;
    mcv_seen = m_cmd_valid;
    if (req_ready !== 3'b100) begin
      $display("FAIL zero_grant: got %b want 100", req_ready);
      fails++;
    end
    tests++;
    tick();
    req_valid = '0;
    #1;
    mcv_seen = mcv_seen | m_cmd_valid;
    if (req_done !== 3'b100 || busy !== 1'b0) begin
      $display("FAIL zero_done: got done=%b busy=%b want 100/0", req_done, busy);
      fails++;
    end
    tests++;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      mcv_seen = mcv_seen | m_cmd_valid;
    end
    if (mcv_seen !== 1'b0) begin
      $display("FAIL zero_no_cmd: got m_cmd_valid seen=%b want 0", mcv_seen);
      fails++;
    end
    tests++;
    m_cmd_ready = 1'b0;
  endtask

  task automatic test_cmd_stall();
    int unstable;
    unstable = 0;
    req_valid = 3'b001; req_addr[0] = 32'hDEAD_BEE0; req_len[0] = 16'd2; req_we[0] = 1'b1;
    m_cmd_ready = 1'b0; m_beat = 1'b0;
    #1;
    if (req_ready !== 3'b001) begin
      $display("FAIL stall_grant: got %b want 001", req_ready);
      fails++;
    end
    tests++;
    tick();
    req_valid = '0;
    m_beat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (m_cmd_valid !== 1'b1 || m_cmd_addr !== 32'hDEAD_BEE0 || m_cmd_len !== 16'd2 ||
          m_cmd_we !== 1'b1) unstable++;
      tick();
    end
    if (unstable !== 0) begin
      $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable);
      fails++;
    end
    tests++;
    m_cmd_ready = 1'b1;
    #1;
    if (m_cmd_valid !== 1'b1) begin
      $display("FAIL stall_handshake: got mcv=%b want 1", m_cmd_valid);
      fails++;
    end
    tests++;
    tick();
    m_cmd_ready = 1'b0;
    #1;
    if (m_cmd_valid !== 1'b0 || req_done !== 3'b000) begin
      $display("FAIL stall_beat1: got mcv=%b done=%b want 0/000", m_cmd_valid, req_done);
      fails++;
    end
    tests++;
    tick();
    #1;
    if (req_done !== 3'b000) begin
      $display("FAIL stall_beat2: got done=%b want 000", req_done);
      fails++;
    end
    tests++;
    tick();
    m_beat = 1'b0;
    #1;
    if (req_done !== 3'b001) begin
      $display("FAIL stall_done: got done=%b want 001", req_done);
      fails++;
    end
    tests++;
    tick();
  endtask

  task automatic test_round_robin();
    int grant_who[$];
    int hs_cyc[$];
    int done_cyc[$];
    int done_who[$];
    int exp_order[4] = '{0, 1, 2, 0};
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) req_len[i] = 16'd4;
    m_cmd_ready = 1'b1; m_beat = 1'b1;
    for (int c = 0; c < 26; c++) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] === 1'b1) grant_who.push_back(i);
        if (req_done[i] === 1'b1) begin
          done_who.push_back(i);
          done_cyc.push_back(c);
        end
      end
      if (m_cmd_valid === 1'b1 && m_cmd_ready === 1'b1) hs_cyc.push_back(c);
      tick();
    end
    if (grant_who.size() !== 5 || done_cyc.size() !== 4 || hs_cyc.size() !== 5) begin
      $display("FAIL rr_counts: got grants=%0d dones=%0d cmds=%0d want 5/4/5",
               grant_who.size(), done_cyc.size(), hs_cyc.size());
      fails++;
    end
    tests++;
    for (int i = 0; i < 4; i++) begin
      if (i < grant_who.size()) begin
        if (grant_who[i] !== exp_order[i]) begin
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_who[i], exp_order[i]);
          fails++;
        end
        tests++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i < done_cyc.size() && i < hs_cyc.size()) begin
        if (done_cyc[i] - hs_cyc[i] !== 5 || done_who[i] !== exp_order[i]) begin
          $display("FAIL rr_done_lat[%0d]: got +%0d req %0d want +5 req %0d",
                   i, done_cyc[i] - hs_cyc[i], done_who[i], exp_order[i]);
          fails++;
        end
        tests++;
      end
    end
    req_valid = '0;
    repeat (8) tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    logic [NREQ-1:0] done_seen;
    do_reset();
    // A completed burst by requester 0 makes requester 1 next in line.
    req_valid = 3'b001; req_len[0] = 16'd1; m_cmd_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    m_beat = 1'b1;
    tick();
    m_beat = 1'b0;
    req_valid = 3'b001; req_len[0] = 16'd5;
    #1;
    if (req_ready !== 3'b001) begin
      $display("FAIL rstmid_grant: got %b want 001", req_ready);
      fails++;
    end
    tests++;
    tick();
    req_valid = '0;
    tick();
    m_beat = 1'b1;
    tick();
    tick();
    m_beat = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    if ({req_ready, req_done, owner, m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_we, busy, err} !== '0) begin
      $display("FAIL rstmid_outputs: got %h want 0",
               {req_ready, req_done, owner, m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_we, busy, err});
      fails++;
    end
    tests++;
    done_seen = '0;
    m_beat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      done_seen = done_seen | req_done;
    end
    m_beat = 1'b0;
    if (done_seen !== 3'b000) begin
      $display("FAIL rstmid_no_done: got %b want 000", done_seen);
      fails++;
    end
    tests++;
    req_valid = 3'b011; req_len[0] = 16'd1; req_len[1] = 16'd1;
    #1;
    if (req_ready !== 3'b001) begin
      $display("FAIL rstmid_rearb: got %b want 001", req_ready);
      fails++;
    end
    tests++;
    tick();
    req_valid = '0;
    tick();
    m_beat = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    req_valid = 3'b100; req_len[2] = 16'd3; m_cmd_ready = 1'b1; m_beat = 1'b0;
    #1;
    if (req_ready !== 3'b100) begin
      $display("FAIL wd_grant: got %b want 100", req_ready);
      fails++;
    end
    tests++;
    tick();
    req_valid = '0;
    tick();
    m_cmd_ready = 1'b0;
    repeat (15) tick();
    #1;
    if (err !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL wd_pre: got err=%b busy=%b want 0/1", err, busy);
      fails++;
    end
    tests++;
    tick();
    #1;
`ifdef MM_ARB_WATCHDOG_EN
    if (err !== 1'b1 || req_done !== 3'b100 || busy !== 1'b0) begin
      $display("FAIL wd_fire: got err=%b done=%b busy=%b want 1/100/0", err, req_done, busy);
      fails++;
    end
    tests++;
    tick();
    #1;
    if (err !== 1'b1 || req_done !== 3'b000) begin
      $display("FAIL wd_sticky: got err=%b done=%b want 1/000", err, req_done);
      fails++;
    end
    tests++;
`else
    if (err !== 1'b0 || req_done !== 3'b000 || busy !== 1'b1) begin
      $display("FAIL wd_off: got err=%b done=%b busy=%b want 0/000/1", err, req_done, busy);
      fails++;
    end
    tests++;
    repeat (30) tick();
    #1;
    if (err !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL wd_off_long: got err=%b busy=%b want 0/1", err, busy);
      fails++;
    end
    tests++;
    m_beat = 1'b1;
    tick();
    tick();
    tick();
    m_beat = 1'b0;
    #1;
    if (req_done !== 3'b100) begin
      $display("FAIL wd_off_done: got %b want 100", req_done);
      fails++;
    end
    tests++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    req_we = '0;
    m_cmd_ready = 1'b0;
    m_beat = 1'b0;
    test_reset();
    test_single();
    test_len_zero();
    test_cmd_stall();
    test_round_robin();
    test_reset_mid_burst();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
